// File: rtl/contact_bounce_gen_pkg.sv
// Shared types and constants for the contact bounce emulator.
package bounce_gen_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      BOUNCE = 1'b1
   } state_t;

   localparam int          LFSR_W       = 16;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Right-shifting Galois step for x^16+x^14+x^13+x^11.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
      return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
   endfunction

endpackage

// File: rtl/contact_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed falls back to the default seed.
module lfsr16
   import bounce_gen_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= (seed == '0) ? DEFAULT_SEED : seed;
      end else begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/contact_bounce_gen.sv
// Contact-bounce emulator: turns a clean level into a seeded bouncing contact.
// Optional transition counter on `edges` enabled by `define BOUNCE_GEN_EDGE_CNT_EN.
module contact_bounce_gen
   import bounce_gen_pkg::*;
#(
   parameter int          BOUNCE_TOTAL = 30,
   parameter int          SEG_BITS     = 3,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lvl,
   output logic        but,
   output logic        busy
`ifdef BOUNCE_GEN_EDGE_CNT_EN
   ,
   output logic [15:0] edges
`endif
);

   localparam int            CW        = $clog2(BOUNCE_TOTAL + 1);
   localparam logic [CW-1:0] BCNT_LOAD = CW'(BOUNCE_TOTAL - 1);

   state_t              state, state_nxt;
   logic                target, target_nxt;
   logic [CW-1:0]       bcnt, bcnt_nxt;
   logic [SEG_BITS-1:0] seg, seg_nxt;
   logic                but_nxt, busy_nxt;
   logic                seg_advance;
   logic [LFSR_W-1:0]   lfsr;
   logic [SEG_BITS-1:0] newlen;
   logic                unused_lfsr_bits;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (SEED),
      .q     (lfsr)
   );

   assign newlen           = lfsr[SEG_BITS:1];
   assign unused_lfsr_bits = ^lfsr[LFSR_W-1:SEG_BITS+1];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      target_nxt  = target;
      bcnt_nxt    = bcnt;
      seg_nxt     = seg;
      but_nxt     = but;
      busy_nxt    = busy;
      seg_advance = 1'b0;

      unique case (state)
         IDLE: begin
            if (lvl != but) begin
               state_nxt  = BOUNCE;
               target_nxt = lvl;
               bcnt_nxt   = BCNT_LOAD;
               seg_nxt    = newlen;
               but_nxt    = ~but;
               busy_nxt   = 1'b1;
            end
         end
         BOUNCE: begin
            if (lvl != target) begin
               // Target moved mid-window: restart the window, keep bouncing.
               target_nxt  = lvl;
               bcnt_nxt    = BCNT_LOAD;
               seg_advance = 1'b1;
            end else if (bcnt == '0) begin
               but_nxt   = target;
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else begin
               bcnt_nxt    = bcnt - CW'(1);
               seg_advance = 1'b1;
            end
         end
         default: ;
      endcase

      if (seg_advance) begin
         if (seg == '0) begin
            but_nxt = lfsr[0];
            seg_nxt = newlen;
         end else begin
            seg_nxt = seg - SEG_BITS'(1);
         end
      end
   end

   // NOTE: only control/datapath registers exist here, and all of them take a reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         target <= 1'b0;
         bcnt   <= '0;
         seg    <= '0;
         but    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         target <= target_nxt;
         bcnt   <= bcnt_nxt;
         seg    <= seg_nxt;
         but    <= but_nxt;
         busy   <= busy_nxt;
      end
   end

`ifdef BOUNCE_GEN_EDGE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edges <= 16'h0000;
      end else if ((but_nxt != but) && (edges != 16'hFFFF)) begin
         edges <= edges + 16'd1;
      end
   end
`endif

endmodule
